// File: rtl/plot_stream_monitor_pkg.sv
// Shared definitions for the plot stream monitor and any scanner-side model.
// Contents: screen constants, coordinate widths, FSM state type, accumulator
// record type and the fold() signature step.
package plot_pkg;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned C_W = 3;

  localparam int unsigned START_X     = 0;
  localparam int unsigned START_Y     = 84;
  localparam int unsigned FRAME_PLOTS = 12800;
  localparam int unsigned X_MAX       = 160;
  localparam int unsigned Y_MAX       = 120;

  typedef enum logic [0:0] {
    ST_HUNT,
    ST_CAPTURE
  } mon_state_t;

  // Per-frame accumulator record; also used as the result register layout.
  typedef struct packed {
    logic [15:0]    cnt;
    logic [15:0]    sig;
    logic [7:0]     oob;
    logic [C_W-1:0] pcol;
    logic           phit;
  } accum_t;

  // One signature step: rotate left by one, then fold the 18-bit plot word
  // {colour, y, x} into 16 bits (low 16 bits plus the top two bits at bit 0).
  function automatic logic [15:0] fold(input logic [15:0]    sig,
                                       input logic [C_W-1:0] colour,
                                       input logic [Y_W-1:0] y,
                                       input logic [X_W-1:0] x);
    logic [17:0] w;
    w = {colour, y, x};
    return {sig[14:0], sig[15]} ^ w[15:0] ^ {14'b0, w[17:16]};
  endfunction

endpackage

// File: rtl/plot_stream_monitor_if.sv
// Pixel plot stream bus as driven by the display scanner into the VGA adapter.
//   plot   : pixel write strobe
//   x      : pixel x
//   y      : pixel y
//   colour : pixel colour
// master = scanner (driver), slave = any tap/receiver (adapter, monitor).
interface plot_stream_monitor_if;
  logic                       plot;
  logic [plot_pkg::X_W-1:0]   x;
  logic [plot_pkg::Y_W-1:0]   y;
  logic [plot_pkg::C_W-1:0]   colour;

  modport master (output plot, x, y, colour);
  modport slave  (input  plot, x, y, colour);
endinterface

// File: rtl/plot_stream_monitor_accum.sv
// plot_accum: per-frame accumulators for the plot stream monitor.
//   clk, resetn       : clock, synchronous active-low reset
//   init              : current plot is plot #1 of a new frame
//   step              : current plot extends the running frame
//   x, y, colour      : current plot
//   probe_x, probe_y  : live probe coordinate
//   acc               : accumulator state (count, signature, oob, probe)
module plot_accum
  import plot_pkg::*;
#(
  parameter int unsigned X_LIMIT = plot_pkg::X_MAX,
  parameter int unsigned Y_LIMIT = plot_pkg::Y_MAX
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           init,
  input  logic           step,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [C_W-1:0] colour,
  input  logic [X_W-1:0] probe_x,
  input  logic [Y_W-1:0] probe_y,
  output accum_t         acc
);

  accum_t acc_q;
  accum_t acc_d;
  accum_t base;

  // init applies the plot on top of a cleared record, so the start plot is
  // counted, folded and checked exactly like any other plot.
  always_comb begin
    acc_d = acc_q;
    base  = acc_q;
    if (init) base = '0;
    if (init || step) begin
      acc_d.cnt  = (base.cnt == '1) ? base.cnt : base.cnt + 16'd1;
      acc_d.sig  = fold(base.sig, colour, y, x);
      acc_d.oob  = base.oob;
      if (32'(x) >= X_LIMIT || 32'(y) >= Y_LIMIT)
        acc_d.oob = (base.oob == '1) ? base.oob : base.oob + 8'd1;
      acc_d.pcol = base.pcol;
      acc_d.phit = base.phit;
      if (x == probe_x && y == probe_y) begin
        acc_d.pcol = colour;
        acc_d.phit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/plot_stream_monitor.sv
// plot_stream_monitor: passive tap on the scanner's pixel plot stream.
// Splits the stream into frames at each start plot and publishes per-frame
// plot count, signature, probe colour/hit and out-of-bounds count through a
// valid/ack result handshake.
//   clk, resetn    : clock, synchronous active-low reset
//   stream         : plot/x/y/colour bus (slave, observe only)
//   probe_x/y      : probe coordinate, compared live on every plot
//   res_ack        : consumer acknowledge of the current result
//   res_*          : completed-frame result registers
//   overrun        : sticky, a result was overwritten before being acked
module plot_stream_monitor #(
  parameter int unsigned START_X     = plot_pkg::START_X,
  parameter int unsigned START_Y     = plot_pkg::START_Y,
  parameter int unsigned FRAME_PLOTS = plot_pkg::FRAME_PLOTS,
  parameter int unsigned X_MAX       = plot_pkg::X_MAX,
  parameter int unsigned Y_MAX       = plot_pkg::Y_MAX
) (
  input  logic                        clk,
  input  logic                        resetn,
  plot_stream_monitor_if.slave        stream,
  input  logic [plot_pkg::X_W-1:0]    probe_x,
  input  logic [plot_pkg::Y_W-1:0]    probe_y,
  input  logic                        res_ack,
  output logic                        res_valid,
  output logic [15:0]                 res_plots,
  output logic [15:0]                 res_sig,
  output logic [plot_pkg::C_W-1:0]    res_probe_col,
  output logic                        res_probe_hit,
  output logic [7:0]                  res_oob,
  output logic                        res_len_err,
  output logic                        overrun
);

  import plot_pkg::*;

  mon_state_t state_q, state_d;
  accum_t     res_q, res_d;
  logic       res_len_err_q, res_len_err_d;
  logic       res_valid_q, res_valid_d;
  logic       overrun_q, overrun_d;

  logic       start;
  logic       boundary;
  logic       acc_init;
  logic       acc_step;
  accum_t     acc;

  plot_accum #(
    .X_LIMIT (X_MAX),
    .Y_LIMIT (Y_MAX)
  ) u_accum (
    .clk     (clk),
    .resetn  (resetn),
    .init    (acc_init),
    .step    (acc_step),
    .x       (stream.x),
    .y       (stream.y),
    .colour  (stream.colour),
    .probe_x (probe_x),
    .probe_y (probe_y),
    .acc     (acc)
  );

  always_comb begin
    start    = stream.plot && (32'(stream.x) == START_X) && (32'(stream.y) == START_Y);
    boundary = start && (state_q == ST_CAPTURE);
    acc_init = start;
    acc_step = stream.plot && !start && (state_q == ST_CAPTURE);

    state_d       = start ? ST_CAPTURE : state_q;
    res_d         = res_q;
    res_len_err_d = res_len_err_q;
    res_valid_d   = res_valid_q;
    overrun_d     = overrun_q;

    // A boundary captures the pre-update accumulators (the boundary plot
    // belongs to the next frame). It wins over a same-cycle ack, and only an
    // un-acked overwrite counts as an overrun.
    if (boundary) begin
      res_d         = acc;
      res_len_err_d = (32'(acc.cnt) != FRAME_PLOTS);
      res_valid_d   = 1'b1;
      if (res_valid_q && !res_ack) overrun_d = 1'b1;
    end else if (res_valid_q && res_ack) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_HUNT;
      res_q         <= '0;
      res_len_err_q <= 1'b0;
      res_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      res_q         <= res_d;
      res_len_err_q <= res_len_err_d;
      res_valid_q   <= res_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign res_valid     = res_valid_q;
  assign res_plots     = res_q.cnt;
  assign res_sig       = res_q.sig;
  assign res_probe_col = res_q.pcol;
  assign res_probe_hit = res_q.phit;
  assign res_oob       = res_q.oob;
  assign res_len_err   = res_len_err_q;
  assign overrun       = overrun_q;

endmodule
